hash_result_collector: RTL and testbench
========================================

Name: hash_result_collector

Overview:
Response-side companion to the multi-port URAM hash table. The block tracks which read lanes were issued in each lookup batch and captures the wide NUM_RD x DATA_WIDTH result vector after the table's fixed lookup latency. It buffers captured batches and serializes them into a valid/ready stream of per-lane results (lane, tag, data). This replaces XOR-folding of results, so every lookup result is individually observable downstream.

Parameters:
NUM_RD, 16, number of read lanes in the hash table
DATA_WIDTH, 64, width of one lane result
LOOKUP_LATENCY, 4, clk edges from issue to valid rd_out_all (>=1)
FIFO_DEPTH, 4, batch buffer entries (power of 2, >=2)
TAG_WIDTH, 8, batch tag width
LANE_WIDTH, 4, log2(NUM_RD)

Ports:
clk  in  1  clock
reset  in  1  reset
issue_valid  in  1  a lookup batch was issued to the hash table this cycle
issue_mask  in  NUM_RD  lanes carrying real lookups in the batch
issue_tag  in  TAG_WIDTH  batch identifier
issue_ready  out  1  a batch may be issued this cycle
rd_out_all  in  NUM_RD*DATA_WIDTH  hash table result bus; lane j at [j*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts beat
out_lane  out  LANE_WIDTH  lane index of beat
out_tag  out  TAG_WIDTH  tag of owning batch
out_data  out  DATA_WIDTH  lane result
out_last  out  1  final beat of batch
err_overflow  out  1  sticky: batch issued while issue_ready low

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: out_valid=0, out_last=0, out_lane=0, out_tag=0, out_data=0, err_overflow=0, issue_ready=1. The delay line, FIFO, inflight counter and serializer are all cleared. Reset mid-operation discards all in-flight and buffered batches; no beat for them is ever emitted.
- Delay line: LOOKUP_LATENCY stages carry {valid, mask, tag}. A batch accepted at edge k reaches the capture stage at edge k+LOOKUP_LATENCY. At that edge, rd_out_all is sampled together with mask and tag.
- Accept: a batch is accepted when issue_valid=1 and issue_ready=1. If issue_valid=1 and issue_ready=0, the batch is dropped and err_overflow is set; err_overflow clears only on reset.
- Zero mask: a batch with issue_mask=0 travels the delay line and decrements inflight, but is not written to the FIFO.
- Credit: inflight counts accepted batches still in the delay line. issue_ready = (fifo_count + inflight) < FIFO_DEPTH. This guarantees a captured batch always finds a free FIFO slot.
- FIFO: push on capture, pop when the serializer retires a batch. Simultaneous push and pop leaves the count unchanged. When FIFO_DEPTH is reached, wrap-around uses power-of-2 pointers.
- Serializer FSM:
  - IDLE: when the FIFO is non-empty, load the head entry into the working register and go to EMIT.
  - EMIT: present the lowest remaining set mask bit as out_lane, with out_data = that lane's slice and out_tag = the entry tag. out_last=1 when no higher set bit remains.
  - On out_valid & out_ready: clear that bit. If the beat was last, pop the FIFO and go to LOAD if the FIFO still holds another entry, else IDLE. Otherwise advance to the next set bit in the following cycle.
  - LOAD is a single cycle, identical to the IDLE load. No bubble is required beyond one cycle per batch.
- Output stability: out_* are registered and stable while out_valid=1 and out_ready=0. out_valid never deasserts without a handshake, except on reset.
- First-beat latency: for an empty block, a batch issued at edge k gives out_valid=1 in the cycle after edge k+LOOKUP_LATENCY+1. Throughput is one beat per cycle within a batch.
- Beat ordering: lanes ascend within a batch, and batches leave in issue order.
- Width rules: inflight and fifo_count are log2(FIFO_DEPTH)+1 bits wide, and the comparison is unsigned.

Test Plan:
1. Single batch: LOOKUP_LATENCY=4, issue mask=16'h0005, tag=8'h11, lane0=64'hA, lane2=64'hC. Required: 2 beats (lane0 data A last=0; lane2 data C last=1 tag 11). First out_valid appears in the cycle after edge k+5.
2. Full mask with out_ready held 1: 16 consecutive beats, lanes 0..15, out_last only on lane 15, no gaps.
3. Backpressure and credit: out_ready=0, issue 4 batches back-to-back. issue_ready drops to 0 after the 4th; a 5th issue_valid sets err_overflow=1 and is dropped. Releasing out_ready drains exactly 4 batches in tag order.
4. Zero-mask batch issued between tags 1 and 2 produces no beats. Credit returns to 4 once everything drains.
5. Stall stability: out_ready toggles 0/1 each cycle. out_lane/out_data/out_tag stay constant while stalled and no beat is duplicated or lost.
6. Reset mid-drain: reset asserted during EMIT of a 3-beat batch with 2 more batches in flight. The next cycle shows out_valid=0, issue_ready=1, err_overflow=0, and no stale beats after reset deasserts.

Source files
------------

// File: rtl/hash_result_collector.sv
// hash_result_collector
// Tracks lookup batches issued to the multi-port hash table. It captures the wide
// result bus after the fixed lookup latency and buffers each captured batch. It then
// replays every issued lane as one valid/ready beat (lane, tag, data, last).
//
// Serializer states:
//   state  | meaning
//   S_IDLE | no batch being emitted; load the FIFO head as soon as one exists
//   S_LOAD | previous batch just retired and another is queued; load it now
//   S_EMIT | presenting beats of the head batch, one set mask bit at a time
//
// The head entry stays in the FIFO until its last beat is accepted. Its tag and
// data are read directly from the FIFO, so only the remaining-lane mask is kept
// in a working register.
module hash_result_collector #(
  parameter int NUM_RD         = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int LOOKUP_LATENCY = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_WIDTH      = 8,
  parameter int LANE_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic [NUM_RD-1:0]            issue_mask,
  input  logic [TAG_WIDTH-1:0]         issue_tag,
  output logic                         issue_ready,
  input  logic [NUM_RD*DATA_WIDTH-1:0] rd_out_all,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANE_WIDTH-1:0]        out_lane,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         err_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

  state_t state, next_state;

  logic                 dl_valid [LOOKUP_LATENCY];
  logic [NUM_RD-1:0]    dl_mask  [LOOKUP_LATENCY];
  logic [TAG_WIDTH-1:0] dl_tag   [LOOKUP_LATENCY];

  logic [NUM_RD-1:0][DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [NUM_RD-1:0]                 fifo_mask [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]              fifo_tag  [FIFO_DEPTH];
  logic [PW-1:0]                     wr_ptr, rd_ptr;
  logic [CW-1:0]                     fifo_count, inflight;
  logic [CW:0]                       credit_sum;

  logic                  accept, cap_valid, push, pop, load, advance;
  logic [NUM_RD-1:0]     cap_mask, work_mask, sel_mask;
  logic [LANE_WIDTH-1:0] nxt_lane;
  logic                  nxt_last;

  assign accept     = issue_valid & issue_ready;
  assign cap_valid  = dl_valid[LOOKUP_LATENCY-1];
  assign cap_mask   = dl_mask[LOOKUP_LATENCY-1];
  // Zero-mask batches return their credit at capture but never occupy a slot.
  assign push       = cap_valid & (|cap_mask);
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue_ready = credit_sum < (CW+1)'(FIFO_DEPTH);

  // Delay line mirroring the hash table pipeline; only the valid bits need reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LOOKUP_LATENCY; i++) dl_valid[i] <= 1'b0;
    end else begin
      dl_valid[0] <= accept;
      dl_mask[0]  <= issue_mask;
      dl_tag[0]   <= issue_tag;
      for (int i = 1; i < LOOKUP_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_mask[i]  <= dl_mask[i-1];
        dl_tag[i]   <= dl_tag[i-1];
      end
    end
  end

  // Credit counters, pointers and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight     <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_overflow <= 1'b0;
    end else begin
      case ({accept, cap_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (issue_valid && !issue_ready) err_overflow <= 1'b1;
    end
  end

  // Batch storage; emptiness is tracked by the counters, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_out_all;
      fifo_mask[wr_ptr] <= cap_mask;
      fifo_tag[wr_ptr]  <= dl_tag[LOOKUP_LATENCY-1];
    end
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Serializer next-state and load/advance/pop strobes.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    advance    = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          load       = 1'b1;
          next_state = S_EMIT;
        end
      end
      S_LOAD: begin
        load       = 1'b1;
        next_state = S_EMIT;
      end
      S_EMIT: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            pop        = 1'b1;
            next_state = (fifo_count > CW'(1)) ? S_LOAD : S_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Pick the lowest remaining lane: the fresh head mask on load, else the current
  // mask with the lane just accepted removed.
  always_comb begin
    sel_mask = load ? fifo_mask[rd_ptr] : (work_mask & ~(NUM_RD'(1) << out_lane));
    nxt_lane = '0;
    for (int i = NUM_RD - 1; i >= 0; i--) begin
      if (sel_mask[i]) nxt_lane = LANE_WIDTH'(i);
    end
    nxt_last = (sel_mask & ~(NUM_RD'(1) << nxt_lane)) == '0;
  end

  // Registered beat outputs; they change only on load, advance, pop or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_mask <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_tag   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      work_mask <= sel_mask;
      out_valid <= 1'b1;
      out_lane  <= nxt_lane;
      out_tag   <= fifo_tag[rd_ptr];
      out_data  <= fifo_data[rd_ptr][nxt_lane];
      out_last  <= nxt_last;
    end else if (advance) begin
      work_mask <= sel_mask;
      out_lane  <= nxt_lane;
      out_data  <= fifo_data[rd_ptr][nxt_lane];
      out_last  <= nxt_last;
    end else if (pop) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hash_result_collector.sv
// Testbench for hash_result_collector. It uses a batch-level reference model: a
// queue of pending batches with their capture edge, a queue of expected beats and
// an outstanding-batch credit count.
module tb_hash_result_collector;

  localparam int NUM_RD = 16;
  localparam int DW     = 64;
  localparam int LAT    = 4;
  localparam int DEPTH  = 4;
  localparam int TW     = 8;
  localparam int LW     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic [NUM_RD-1:0] issue_mask;
  logic [TW-1:0]     issue_tag;
  logic              issue_ready;
  logic [NUM_RD*DW-1:0] rd_out_all;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     out_lane;
  logic [TW-1:0]     out_tag;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              err_overflow;

  always #5 clk = ~clk;

  hash_result_collector #(
    .NUM_RD(NUM_RD), .DATA_WIDTH(DW), .LOOKUP_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH), .TAG_WIDTH(TW), .LANE_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_mask(issue_mask), .issue_tag(issue_tag),
    .issue_ready(issue_ready), .rd_out_all(rd_out_all),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_tag(out_tag), .out_data(out_data), .out_last(out_last),
    .err_overflow(err_overflow)
  );

  typedef struct {
    logic [LW-1:0] lane;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [NUM_RD-1:0] mask;
    logic [TW-1:0]     tag;
    int                cap_edge;
  } pend_t;

  beat_t exp_q[$];
  pend_t pend_q[$];
  int    cyc = 0;
  int    outstanding = 0;
  logic  exp_ovf = 1'b0;
  bit    armed = 0;
  bit    prev_stall = 0;
  bit    rd_fixed = 0;
  logic [LW-1:0] s_lane;
  logic [TW-1:0] s_tag;
  logic [DW-1:0] s_data;
  logic          s_last;
  int    checks = 0;
  int    errors = 0;

  task automatic randomize_rd();
    for (int j = 0; j < NUM_RD * DW / 32; j++) rd_out_all[j*32 +: 32] = $urandom();
  endtask

  // One clock: check DUT state, apply this edge's effects to the model, then advance.
  task automatic tick();
    beat_t b;
    pend_t p;
    bit    exp_ready;
    exp_ready = (outstanding < DEPTH);
    if (armed && !reset) begin
      checks++;
      if (issue_ready !== exp_ready) begin
        errors++;
        $display("FAIL issue_ready cyc=%0d got %b expected %b", cyc, issue_ready, exp_ready);
      end
      checks++;
      if (err_overflow !== exp_ovf) begin
        errors++;
        $display("FAIL err_overflow cyc=%0d got %b expected %b", cyc, err_overflow, exp_ovf);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_lane !== s_lane || out_tag !== s_tag ||
            out_data !== s_data || out_last !== s_last) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got v=%b lane=%0d tag=%h data=%h last=%b expected v=1 lane=%0d tag=%h data=%h last=%b",
                   cyc, out_valid, out_lane, out_tag, out_data, out_last, s_lane, s_tag, s_data, s_last);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_beat cyc=%0d got valid lane=%0d tag=%h expected no beat", cyc, out_lane, out_tag);
        end else if (out_ready) begin
          b = exp_q.pop_front();
          if (out_lane !== b.lane || out_tag !== b.tag || out_data !== b.data || out_last !== b.last) begin
            errors++;
            $display("FAIL beat cyc=%0d got lane=%0d tag=%h data=%h last=%b expected lane=%0d tag=%h data=%h last=%b",
                     cyc, out_lane, out_tag, out_data, out_last, b.lane, b.tag, b.data, b.last);
          end
          if (b.last) outstanding--;
        end
      end
      while (pend_q.size() > 0 && pend_q[0].cap_edge == cyc + 1) begin
        p = pend_q.pop_front();
        if (p.mask == '0) outstanding--;
        for (int j = 0; j < NUM_RD; j++) begin
          if (p.mask[j]) begin
            b.lane = LW'(j);
            b.tag  = p.tag;
            b.data = rd_out_all[j*DW +: DW];
            b.last = ((p.mask >> (j + 1)) == '0);
            exp_q.push_back(b);
          end
        end
      end
      if (issue_valid) begin
        if (exp_ready) begin
          pend_q.push_back('{mask: issue_mask, tag: issue_tag, cap_edge: cyc + 1 + LAT});
          outstanding++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      s_lane = out_lane; s_tag = out_tag; s_data = out_data; s_last = out_last;
    end else begin
      prev_stall = 0;
    end
    @(posedge clk);
    cyc++;
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      outstanding = 0;
      exp_ovf = 1'b0;
      armed = 1;
    end
    @(negedge clk);
    if (!rd_fixed) randomize_rd();
  endtask

  task automatic do_issue(input logic [NUM_RD-1:0] mask, input logic [TW-1:0] tag);
    issue_valid = 1'b1;
    issue_mask  = mask;
    issue_tag   = tag;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid got out_valid=%b expected 1 within %0d cycles", out_valid, budget);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() > 0 || pend_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d beats %0d batches outstanding expected 0 0", exp_q.size(), pend_q.size());
    end
    checks++;
    if (issue_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle got issue_ready=%b out_valid=%b expected 1 0", issue_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; issue_valid = 1'b0; issue_mask = '0; issue_tag = '0; out_ready = 1'b0;
    randomize_rd();
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_lane !== '0 || out_tag !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b last=%b lane=%0d tag=%h data=%h expected all 0",
               out_valid, out_last, out_lane, out_tag, out_data);
    end
    checks++;
    if (issue_ready !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got issue_ready=%b err_overflow=%b expected 1 0", issue_ready, err_overflow);
    end
  endtask

  task automatic test_single();
    rd_fixed = 1;
    rd_out_all = '0;
    rd_out_all[0*DW +: DW] = 64'hA;
    rd_out_all[2*DW +: DW] = 64'hC;
    out_ready = 1'b1;
    do_issue(16'h0005, 8'h11);
    for (int i = 0; i < LAT; i++) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got out_valid=%b expected 0 after edge k+%0d", out_valid, LAT);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 4'd0 || out_data !== 64'hA || out_last !== 1'b0 || out_tag !== 8'h11) begin
      errors++;
      $display("FAIL single_beat0 got v=%b lane=%0d data=%h last=%b tag=%h expected 1 0 a 0 11",
               out_valid, out_lane, out_data, out_last, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 4'd2 || out_data !== 64'hC || out_last !== 1'b1 || out_tag !== 8'h11) begin
      errors++;
      $display("FAIL single_beat1 got v=%b lane=%0d data=%h last=%b tag=%h expected 1 2 c 1 11",
               out_valid, out_lane, out_data, out_last, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end got out_valid=%b expected 0", out_valid);
    end
    rd_fixed = 0;
    drain(40);
  endtask

  task automatic test_full_mask();
    out_ready = 1'b1;
    do_issue(16'hFFFF, 8'h22);
    wait_valid(20);
    for (int i = 0; i < NUM_RD; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_lane !== LW'(i) || out_last !== (i == NUM_RD - 1)) begin
        errors++;
        $display("FAIL full_mask beat %0d got v=%b lane=%0d last=%b expected 1 %0d %b",
                 i, out_valid, out_lane, out_last, i, (i == NUM_RD - 1));
      end
      tick();
    end
    drain(40);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int t = 1; t <= DEPTH; t++) do_issue(NUM_RD'($urandom_range(1, 65535)), TW'(t));
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL credit_full got issue_ready=%b expected 0", issue_ready);
    end
    do_issue(16'h00F0, 8'h05);
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow got err_overflow=%b expected 1", err_overflow);
    end
    for (int i = 0; i < 10; i++) tick();
    drain(200);
  endtask

  task automatic test_zero_mask();
    out_ready = 1'b1;
    do_issue(NUM_RD'($urandom_range(1, 65535)), 8'h31);
    do_issue(16'h0000, 8'h3F);
    do_issue(NUM_RD'($urandom_range(1, 65535)), 8'h32);
    drain(200);
    out_ready = 1'b0;
    for (int t = 0; t < DEPTH; t++) begin
      checks++;
      if (issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL credit_return slot %0d got issue_ready=%b expected 1", t, issue_ready);
      end
      do_issue(NUM_RD'($urandom_range(1, 255)), TW'(8'h40 + t));
    end
    drain(200);
  endtask

  task automatic test_stall();
    for (int c = 0; c < 120; c++) begin
      out_ready = c[0];
      if ($urandom_range(0, 2) == 0 && outstanding < DEPTH) begin
        issue_valid = 1'b1;
        issue_mask  = ($urandom_range(0, 7) == 0) ? '0 : NUM_RD'($urandom_range(1, 65535));
        issue_tag   = TW'($urandom_range(0, 255));
      end else begin
        issue_valid = 1'b0;
      end
      tick();
    end
    issue_valid = 1'b0;
    drain(400);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b0;
    do_issue(16'h0013, 8'h51);
    do_issue(NUM_RD'($urandom_range(1, 65535)), 8'h52);
    do_issue(NUM_RD'($urandom_range(1, 65535)), 8'h53);
    wait_valid(20);
    out_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || issue_ready !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got out_valid=%b issue_ready=%b err_overflow=%b expected 0 1 0",
               out_valid, issue_ready, err_overflow);
    end
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stale_beats got %0d beats after reset expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_mask();
    test_backpressure();
    test_zero_mask();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
